// File: rtl/jt900h_pfq.sv
// JT900H instruction prefetch queue: 16-bit bus words into a byte FIFO with 4-byte lookahead.
// Optional stall counter port enabled by defining JT900H_PFQ_STALL_CNT_EN.
module jt900h_pfq #(
  parameter int DEPTH = 8,
  parameter int AW    = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_new,
  input  logic [2:0]    need,
  input  logic [2:0]    adv,
  output logic [7:0]    md,
  output logic [31:0]   op,
  output logic [AW-1:0] pc,
  output logic [3:0]    cnt,
  output logic          q_busy,
  output logic          err,
  output logic          bus_rd,
  output logic [AW-1:0] bus_addr,
  input  logic [15:0]   bus_din,
  input  logic          bus_ack
`ifdef JT900H_PFQ_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t          r_state, w_state_next;
  logic [7:0]      r_mem [DEPTH];
  logic [PW-1:0]   r_rd, r_wr, w_wr_next;
  logic [3:0]      r_cnt;
  logic [AW-1:0]   r_pc, r_fa, r_bus_addr;
  logic            r_skip, r_err, r_bus_rd;
  logic            w_issue, w_take, w_illegal, w_space;
  logic [1:0]      w_nwr;
  logic [31:0]     w_op;

  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input logic [2:0] n);
    logic [PW:0] s;
    s = (PW+1)'(p) + (PW+1)'(n);
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  assign w_take    = (r_state == S_REQ) && bus_ack && !pc_load;
  assign w_nwr     = w_take ? (r_skip ? 2'd1 : 2'd2) : 2'd0;
  assign w_illegal = {1'b0, adv} > r_cnt;
  assign w_space   = r_cnt <= 4'(DEPTH - 2);
  assign w_wr_next = wrap(r_wr, {1'b0, w_nwr});

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      S_IDLE: if (!pc_load && w_space) begin
        w_issue      = 1'b1;
        w_state_next = S_REQ;
      end
      S_REQ: begin
        if (bus_ack)      w_state_next = S_IDLE;
        else if (pc_load) w_state_next = S_DROP;
      end
      S_DROP: if (bus_ack) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_state <= S_IDLE;
    else if (cen) r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= '0;
      r_fa       <= '0;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_skip     <= 1'b0;
      r_err      <= 1'b0;
      r_bus_rd   <= 1'b0;
      r_bus_addr <= '0;
    end else if (cen) begin
      if (w_issue) begin
        r_bus_rd   <= 1'b1;
        r_bus_addr <= r_fa;
      end else if (r_state != S_IDLE && bus_ack) begin
        r_bus_rd <= 1'b0;
      end
      // A flush wins over both the advance and any data arriving this cycle
      if (pc_load) begin
        r_fa   <= {pc_new[AW-1:1], 1'b0};
        r_skip <= pc_new[0];
        r_pc   <= pc_new;
        r_cnt  <= '0;
        r_rd   <= '0;
        r_wr   <= '0;
        r_err  <= 1'b0;
      end else begin
        if (w_take) begin
          r_fa   <= r_fa + AW'(2);
          r_skip <= 1'b0;
        end
        r_wr <= w_wr_next;
        r_pc <= r_pc + AW'(adv);
        if (w_illegal) begin
          r_cnt <= '0;
          r_rd  <= w_wr_next;
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + {2'b00, w_nwr} - {1'b0, adv};
          r_rd  <= wrap(r_rd, adv);
        end
      end
    end
  end

  // Storage has no reset; bytes beyond cnt are masked on the read side
  always_ff @(posedge clk) begin
    if (cen && w_take) begin
      if (r_skip) begin
        r_mem[r_wr] <= bus_din[15:8];
      end else begin
        r_mem[r_wr]             <= bus_din[7:0];
        r_mem[wrap(r_wr, 3'd1)] <= bus_din[15:8];
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_op
    assign w_op[gi*8 +: 8] = (4'(gi) < r_cnt) ? r_mem[wrap(r_rd, 3'(gi))] : 8'h00;
  end

`ifdef JT900H_PFQ_STALL_CNT_EN
  logic [15:0] r_stall;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_stall <= '0;
    else if (cen && q_busy && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
  end
  assign stall_cnt = r_stall;
`endif

  assign op       = w_op;
  assign md       = w_op[7:0];
  assign pc       = r_pc;
  assign cnt      = r_cnt;
  assign q_busy   = r_cnt < {1'b0, need};
  assign err      = r_err;
  assign bus_rd   = r_bus_rd;
  assign bus_addr = r_bus_addr;
endmodule

// File: tb/tb_jt900h_pfq.sv
// Scoreboard bench for jt900h_pfq: a byte-stream model predicts every cycle's outputs,
// a separate monitor compares them against the DUT.
module tb_jt900h_pfq;
  localparam int DEPTH = 8;
  localparam int AW    = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen, pc_load, bus_ack, q_busy, err, bus_rd;
  logic [AW-1:0] pc_new, pc, bus_addr;
  logic [2:0]    need, adv;
  logic [7:0]    md;
  logic [31:0]   op;
  logic [3:0]    cnt;
  logic [15:0]   bus_din;
`ifdef JT900H_PFQ_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  jt900h_pfq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .pc_load(pc_load), .pc_new(pc_new),
    .need(need), .adv(adv), .md(md), .op(op), .pc(pc), .cnt(cnt),
    .q_busy(q_busy), .err(err), .bus_rd(bus_rd), .bus_addr(bus_addr),
    .bus_din(bus_din), .bus_ack(bus_ack)
`ifdef JT900H_PFQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0]    md;
    logic [31:0]   op;
    logic [AW-1:0] pc;
    logic [3:0]    cnt;
    logic          busy;
    logic          err;
  } obs_t;

  int   n_cmp = 0, n_bad = 0;
  obs_t exp_q[$];

  // Reference: the queue holds the program bytes starting at pc
  logic [7:0]    m_q[$];
  logic [AW-1:0] m_pc, m_fa;
  bit            m_skip, m_stale, m_err;
  int            m_stall;
  logic [15:0]   din_ovr[$];
  int            ack_mode;  // 0 never, 1 random, 2 always

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    return (a[16:1] * 16'h9E37) ^ 16'h1234;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.op = '0;
    for (int i = 0; i < 4; i++)
      if (i < m_q.size()) o.op[i*8 +: 8] = m_q[i];
    o.md   = o.op[7:0];
    o.pc   = m_pc;
    o.cnt  = 4'(m_q.size());
    o.busy = m_q.size() < int'(need);
    o.err  = m_err;
    return o;
  endfunction

  task automatic step(input bit pl, input logic [AW-1:0] pn, input logic [2:0] a,
                      input logic [2:0] nd, input bit c);
    bit            rd_pre, ack;
    logic [AW-1:0] addr_pre;
    logic [15:0]   d;
    int            cnt_pre;
    @(negedge clk);
    rd_pre   = bus_rd;
    addr_pre = bus_addr;
    ack      = rd_pre && (ack_mode == 2 || (ack_mode == 1 && $urandom_range(0, 2) == 0));
    d        = mem_word(addr_pre);
    if (ack && c && !pl && !m_stale && din_ovr.size() > 0) d = din_ovr.pop_front();
    pc_load = pl; pc_new = pn; adv = a; need = nd; cen = c;
    bus_ack = ack;
    bus_din = ack ? d : 16'($urandom);
    cnt_pre = m_q.size();
    if (c && cnt_pre < int'(nd)) m_stall++;
    @(posedge clk); #1;
    if (c) begin
      if (pl) begin
        if (ack)         m_stale = 1'b0;
        else if (rd_pre) m_stale = 1'b1;
        m_q.delete();
        m_pc   = pn;
        m_err  = 1'b0;
        m_fa   = {pn[AW-1:1], 1'b0};
        m_skip = pn[0];
      end else begin
        if (ack) begin
          if (m_stale) m_stale = 1'b0;
          else begin
            if (!m_skip) m_q.push_back(d[7:0]);
            m_q.push_back(d[15:8]);
            m_skip = 1'b0;
            m_fa   = m_fa + AW'(2);
          end
        end
        m_pc = m_pc + AW'(a);
        if (int'(a) > cnt_pre) begin
          m_err = 1'b1;
          m_q.delete();
        end else begin
          for (int i = 0; i < int'(a); i++) void'(m_q.pop_front());
        end
      end
      if (!rd_pre && bus_rd) begin
        chk("req_addr", 64'(bus_addr), 64'(m_fa));
        chk("req_space", 64'(cnt_pre <= DEPTH - 2), 64'(1));
      end
    end
    if (rd_pre && !(c && ack)) chk("req_hold", 64'({bus_rd, bus_addr}), 64'({1'b1, addr_pre}));
    exp_q.push_back(model_obs());
  endtask

  initial begin
    forever begin
      @(posedge clk); #2;
      while (exp_q.size() > 0) begin
        obs_t e, g;
        e = exp_q.pop_front();
        g = {md, op, pc, cnt, q_busy, err};
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL obs: got md=%h op=%h pc=%h cnt=%0d busy=%b err=%b expected md=%h op=%h pc=%h cnt=%0d busy=%b err=%b",
                   g.md, g.op, g.pc, g.cnt, g.busy, g.err, e.md, e.op, e.pc, e.cnt, e.busy, e.err);
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] a4;
    cen = 1'b1; pc_load = 1'b0; pc_new = '0; need = '0; adv = '0;
    bus_ack = 1'b0; bus_din = '0; ack_mode = 0;
    m_pc = '0; m_fa = '0; m_skip = 1'b0; m_stale = 1'b0; m_err = 1'b0; m_stall = 0;
    #12;
    chk("rst_md_op", 64'({md, op}), 64'(0));
    chk("rst_pc_cnt", 64'({pc, cnt}), 64'(0));
    chk("rst_bus", 64'({err, bus_rd, bus_addr}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Stall counting right after reset with an empty queue
    repeat (5) step(0, '0, 3'd0, 3'd1, 1'b1);
`ifdef JT900H_PFQ_STALL_CNT_EN
    chk("stall_5", 64'(stall_cnt), 64'(5));
`endif

    // Even target, two words
    ack_mode = 2;
    din_ovr.push_back(16'h3412); din_ovr.push_back(16'h7856);
    step(1, 24'h001000, 3'd0, 3'd0, 1'b1);
    for (int k = 0; k < 20 && m_q.size() != 4; k++) step(0, '0, 3'd0, 3'd0, 1'b1);
    chk("t1_md", 64'(md), 64'(8'h12));
    chk("t1_op", 64'(op), 64'(32'h78563412));
    chk("t1_cnt_pc", 64'({cnt, pc}), 64'({4'd4, 24'h001000}));

    // Odd target takes only the high byte of the first word
    din_ovr.push_back(16'hAABB);
    step(1, 24'h001001, 3'd0, 3'd0, 1'b1);
    for (int k = 0; k < 20 && m_q.size() != 1; k++) step(0, '0, 3'd0, 3'd0, 1'b1);
    chk("t2_md_cnt", 64'({md, cnt}), 64'({8'hAA, 4'd1}));
    chk("t2_pc", 64'(pc), 64'(24'h001001));
    ack_mode = 0;
    for (int k = 0; k < 5 && !bus_rd; k++) step(0, '0, 3'd0, 3'd0, 1'b1);
    chk("t2_next_addr", 64'({bus_rd, bus_addr}), 64'({1'b1, 24'h001002}));

    // Fill to full, then free space one byte at a time
    ack_mode = 2;
    step(1, 24'h000100, 3'd0, 3'd0, 1'b1);
    repeat (30) step(0, '0, 3'd0, 3'd0, 1'b1);
    chk("t3_full", 64'({cnt, bus_rd}), 64'({4'd8, 1'b0}));
    step(0, '0, 3'd1, 3'd0, 1'b1);
    chk("t3_cnt7", 64'({cnt, bus_rd}), 64'({4'd7, 1'b0}));
    step(0, '0, 3'd1, 3'd0, 1'b1);
    chk("t3_cnt6", 64'({cnt, bus_rd}), 64'({4'd6, 1'b0}));
    step(0, '0, 3'd0, 3'd0, 1'b1);
    chk("t3_req", 64'(bus_rd), 64'(1));

    // Flush while a request is outstanding
    a4 = bus_addr;
    ack_mode = 0;
    step(1, 24'h002000, 3'd0, 3'd0, 1'b1);
    chk("t4_held", 64'({bus_rd, bus_addr}), 64'({1'b1, a4}));
    ack_mode = 2;
    step(0, '0, 3'd0, 3'd0, 1'b1);
    chk("t4_dropped", 64'({cnt, bus_rd}), 64'({4'd0, 1'b0}));
    ack_mode = 0;
    for (int k = 0; k < 5 && !bus_rd; k++) step(0, '0, 3'd0, 3'd0, 1'b1);
    chk("t4_addr", 64'({bus_rd, bus_addr}), 64'({1'b1, 24'h002000}));

    // Same-cycle write and advance
    ack_mode = 2;
    step(1, 24'h003001, 3'd0, 3'd0, 1'b1);
    for (int k = 0; k < 20 && m_q.size() != 3; k++) step(0, '0, 3'd0, 3'd0, 1'b1);
    ack_mode = 0;
    for (int k = 0; k < 5 && !bus_rd; k++) step(0, '0, 3'd0, 3'd0, 1'b1);
    din_ovr.push_back(16'h5544);
    ack_mode = 2;
    step(0, '0, 3'd3, 3'd0, 1'b1);
    chk("t5_cnt_md", 64'({cnt, md}), 64'({4'd2, 8'h44}));
    chk("t5_pc", 64'(pc), 64'(24'h003004));

    // Over-advance, error clear, busy
    ack_mode = 0;
    step(0, '0, 3'd1, 3'd0, 1'b1);
    step(0, '0, 3'd2, 3'd0, 1'b1);
    chk("t6_err", 64'({err, cnt}), 64'({1'b1, 4'd0}));
    step(1, 24'h004000, 3'd0, 3'd0, 1'b1);
    chk("t6_clear", 64'(err), 64'(0));
    step(0, '0, 3'd0, 3'd2, 1'b1);
    chk("t6_busy", 64'(q_busy), 64'(1));

    // Randomized traffic with clock-enable gaps and occasional illegal advances
    ack_mode = 1;
    for (int t = 0; t < 3000; t++) begin
      bit            c, pl;
      logic [AW-1:0] pn;
      logic [2:0]    a;
      int            mx;
      c  = $urandom_range(0, 9) != 0;
      pl = $urandom_range(0, 24) == 0;
      pn = ($urandom_range(0, 3) == 0) ? 24'hFFFFFC + 24'($urandom_range(0, 3)) : 24'($urandom);
      mx = (m_q.size() < 4) ? m_q.size() : 4;
      a  = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, mx));
      step(pl, pn, a, 3'($urandom_range(0, 4)), c);
    end
    ack_mode = 0;
    step(0, '0, 3'd0, 3'd0, 1'b1);
    @(posedge clk); #3;
`ifdef JT900H_PFQ_STALL_CNT_EN
    chk("stall_total", 64'(stall_cnt), 64'((m_stall > 65535) ? 65535 : m_stall));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
